// File: rtl/tx_src_ctrl.sv
// Transmit source controller: loads the transmitter holding register either
// from the TX FIFO (one byte per request) or from a DMA channel in BURST-byte bursts.
module tx_src_ctrl #(
    parameter int unsigned BURST = 4
) (
    input  logic        m_clk,
    input  logic        reset,
    input  logic        fifo_en,
    input  logic        dma_mode,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    input  logic [7:0]  fifo_data,
    output logic        dma_req,
    input  logic        dma_ack,
    input  logic        dma_valid,
    output logic        dma_rdy,
    input  logic [7:0]  dma_data,
    input  logic        thr_ready,
    output logic        thr_load,
    output logic [7:0]  thr_data,
    output logic        busy,
    output logic        src_dma,
    output logic [15:0] tx_count
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BEAT_W = 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FRD   = 3'd1;
    localparam logic [2:0] FWAIT = 3'd2;
    localparam logic [2:0] LOAD  = 3'd3;
    localparam logic [2:0] DREQ  = 3'd4;
    localparam logic [2:0] DXFER = 3'd5;
    localparam logic [2:0] DLOAD = 3'd6;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_nxt;
    logic [DATA_W-1:0] thr_data_nxt;
    logic              src_dma_nxt;
    logic              load_nxt;
    logic              dma_sel;
    logic              accept;

    assign dma_sel = fifo_en & dma_mode;

    // Ready tracks the holding register live so DMA backpressure is immediate
    assign dma_rdy = (state == DXFER) & thr_ready;
    assign accept  = dma_rdy & dma_valid;

    // State register
    always_ff @(posedge m_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath decode
    always_comb begin
        state_nxt    = state;
        beat_nxt     = beat_cnt;
        thr_data_nxt = thr_data;
        src_dma_nxt  = src_dma;
        case (state)
            IDLE: begin
                src_dma_nxt = dma_sel;
                if (thr_ready) begin
                    if (dma_sel) begin
                        state_nxt = DREQ;
                    end else if (!fifo_empty) begin
                        state_nxt = FRD;
                    end
                end
            end
            FRD: begin
                state_nxt = FWAIT;
            end
            FWAIT: begin
                thr_data_nxt = fifo_data;
                state_nxt    = LOAD;
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            DREQ: begin
                // Losing DMA selection before the grant abandons the request
                if (!dma_sel) begin
                    state_nxt = IDLE;
                end else if (dma_ack) begin
                    beat_nxt  = '0;
                    state_nxt = DXFER;
                end
            end
            DXFER: begin
                if (accept) begin
                    thr_data_nxt = dma_data;
                    beat_nxt     = beat_cnt + BEAT_W'(1);
                    state_nxt    = DLOAD;
                end
            end
            DLOAD: begin
                if (beat_cnt == BEAT_W'(BURST)) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DXFER;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign load_nxt = (state_nxt == LOAD) | (state_nxt == DLOAD);

    // Output and datapath registers, decoded from the next state so strobes align with it
    always_ff @(posedge m_clk) begin
        if (reset) begin
            beat_cnt <= '0;
            thr_data <= '0;
            src_dma  <= 1'b0;
            tx_count <= '0;
            fifo_rd  <= 1'b0;
            dma_req  <= 1'b0;
            thr_load <= 1'b0;
            busy     <= 1'b0;
        end else begin
            beat_cnt <= beat_nxt;
            thr_data <= thr_data_nxt;
            src_dma  <= src_dma_nxt;
            tx_count <= tx_count + CNT_W'(load_nxt);
            fifo_rd  <= (state_nxt == FRD);
            dma_req  <= (state_nxt == DREQ);
            thr_load <= load_nxt;
            busy     <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_tx_src_ctrl.sv
// Scoreboard bench for tx_src_ctrl: expected holding-register bytes are queued
// as they are offered to the DUT and popped on every thr_load.
module tb_tx_src_ctrl;

    localparam int unsigned BURST = 4;

    logic        m_clk = 1'b0;
    logic        reset;
    logic        fifo_en;
    logic        dma_mode;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [7:0]  fifo_data;
    logic        dma_req;
    logic        dma_ack;
    logic        dma_valid;
    logic        dma_rdy;
    logic [7:0]  dma_data;
    logic        thr_ready;
    logic        thr_load;
    logic [7:0]  thr_data;
    logic        busy;
    logic        src_dma;
    logic [15:0] tx_count;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_count = 16'h0000;

    tx_src_ctrl #(.BURST(BURST)) dut (
        .m_clk      (m_clk),
        .reset      (reset),
        .fifo_en    (fifo_en),
        .dma_mode   (dma_mode),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .dma_req    (dma_req),
        .dma_ack    (dma_ack),
        .dma_valid  (dma_valid),
        .dma_rdy    (dma_rdy),
        .dma_data   (dma_data),
        .thr_ready  (thr_ready),
        .thr_load   (thr_load),
        .thr_data   (thr_data),
        .busy       (busy),
        .src_dma    (src_dma),
        .tx_count   (tx_count)
    );

    always #5 m_clk = ~m_clk;

    // Pops one expected byte per load; also flags loads on adjacent cycles
    task automatic monitor();
        logic       prev_load;
        logic [7:0] exp;
        prev_load = 1'b0;
        forever begin
            @(negedge m_clk);
            if (thr_load === 1'b1) begin
                chk_cnt++;
                if (prev_load) begin
                    $display("FAIL load_spacing: got loads on adjacent cycles, required at most one per two");
                end else if (exp_q.size() == 0) begin
                    $display("FAIL load_unexpected: got thr_load with thr_data=%h, required no load", thr_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (thr_data !== exp) begin
                        $display("FAIL load_data: got thr_data=%h, required %h", thr_data, exp);
                    end else begin
                        pass_cnt++;
                    end
                end
            end
            prev_load = (thr_load === 1'b1);
        end
    endtask

    task automatic test_reset();
        logic [5:0] flags;
        reset = 1'b1;
        repeat (2) @(negedge m_clk);
        flags = {fifo_rd, dma_req, dma_rdy, thr_load, busy, src_dma};
        chk_cnt++;
        if (flags !== 6'b0) $display("FAIL reset_flags: got %b, required 000000", flags);
        else pass_cnt++;
        chk_cnt++;
        if (thr_data !== 8'h00) $display("FAIL reset_thr_data: got %h, required 00", thr_data);
        else pass_cnt++;
        chk_cnt++;
        if (tx_count !== 16'h0000) $display("FAIL reset_tx_count: got %h, required 0000", tx_count);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge m_clk);
    endtask

    // One byte through the FIFO path, checking latency, pop count and counter
    task automatic do_fifo_byte(input logic en, input logic mode, input logic [7:0] d);
        int cyc;
        int rd_cnt;
        bit got;
        bit saw_req;
        fifo_en    = en;
        dma_mode   = mode;
        thr_ready  = 1'b1;
        fifo_data  = ~d;
        fifo_empty = 1'b0;
        cyc = 0; rd_cnt = 0; got = 1'b0; saw_req = 1'b0;
        while (!got && cyc < 10) begin
            @(negedge m_clk);
            cyc++;
            if (fifo_rd === 1'b1) begin
                rd_cnt++;
                fifo_data  = d;
                fifo_empty = 1'b1;
                exp_q.push_back(d);
                exp_count++;
            end
            if (dma_req === 1'b1) saw_req = 1'b1;
            if (thr_load === 1'b1) got = 1'b1;
        end
        chk_cnt++;
        if (!got || cyc != 3) $display("FAIL fifo_latency: got load=%0d at cycle %0d, required load at cycle 3", got, cyc);
        else pass_cnt++;
        repeat (2) begin
            @(negedge m_clk);
            if (fifo_rd === 1'b1) rd_cnt++;
            if (dma_req === 1'b1) saw_req = 1'b1;
        end
        chk_cnt++;
        if (rd_cnt != 1 || saw_req) $display("FAIL fifo_pops: got %0d pops req=%0d, required 1 pop req=0", rd_cnt, saw_req);
        else pass_cnt++;
        chk_cnt++;
        if (tx_count !== exp_count) $display("FAIL fifo_tx_count: got %h, required %h", tx_count, exp_count);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0 || src_dma !== 1'b0) $display("FAIL fifo_idle: got busy=%b src_dma=%b, required 0 0", busy, src_dma);
        else pass_cnt++;
    endtask

    task automatic test_fifo_path();
        do_fifo_byte(1'b1, 1'b0, 8'hA5);
    endtask

    task automatic test_fifo_sel_override();
        do_fifo_byte(1'b0, 1'b1, 8'h3C);
    endtask

    task automatic test_idle_hold();
        bit moved;
        moved = 1'b0;
        fifo_en = 1'b1; dma_mode = 1'b0; fifo_empty = 1'b1; thr_ready = 1'b1;
        repeat (3) begin @(negedge m_clk); if (busy !== 1'b0) moved = 1'b1; end
        fifo_empty = 1'b0; thr_ready = 1'b0;
        repeat (3) begin @(negedge m_clk); if (busy !== 1'b0) moved = 1'b1; end
        chk_cnt++;
        if (moved) $display("FAIL idle_hold: got busy while empty or not ready, required idle");
        else pass_cnt++;
        fifo_empty = 1'b1; thr_ready = 1'b1;
        @(negedge m_clk);
    endtask

    // DMA burst of four bytes (LSB first); optional stall or reset after byte 2
    task automatic do_burst(input logic [31:0] bytes, input bit stall, input bit rst_mid);
        int   cyc;
        int   idx;
        bit   stalled;
        bit   bad;
        logic [5:0] flags;
        fifo_empty = 1'b1; thr_ready = 1'b1; dma_valid = 1'b0; dma_ack = 1'b0;
        fifo_en = 1'b1; dma_mode = 1'b1;
        cyc = 0;
        while (dma_req !== 1'b1 && cyc < 20) begin @(negedge m_clk); cyc++; end
        chk_cnt++;
        if (dma_req !== 1'b1 || src_dma !== 1'b1) $display("FAIL dma_request: got req=%b src_dma=%b, required 1 1", dma_req, src_dma);
        else pass_cnt++;
        @(negedge m_clk);
        chk_cnt++;
        if (dma_req !== 1'b1) $display("FAIL dma_req_hold: got %b, required 1 until ack", dma_req);
        else pass_cnt++;
        dma_ack = 1'b1;
        @(negedge m_clk);
        dma_ack = 1'b0;
        chk_cnt++;
        if (dma_req !== 1'b0 || dma_rdy !== 1'b1) $display("FAIL dma_after_ack: got req=%b rdy=%b, required 0 1", dma_req, dma_rdy);
        else pass_cnt++;
        dma_mode = 1'b0;
        idx = 0; cyc = 0; stalled = 1'b0;
        while (idx < 4 && cyc < 100) begin
            dma_valid = 1'b1;
            dma_data  = bytes[8*idx +: 8];
            #1;
            if (dma_rdy === 1'b1) begin
                exp_q.push_back(dma_data);
                exp_count++;
                idx++;
            end
            @(negedge m_clk);
            cyc++;
            if (rst_mid && idx == 2) begin
                reset = 1'b1; dma_valid = 1'b0;
                @(negedge m_clk);
                flags = {fifo_rd, dma_req, dma_rdy, thr_load, busy, src_dma};
                chk_cnt++;
                if (flags !== 6'b0 || thr_data !== 8'h00 || tx_count !== 16'h0000)
                    $display("FAIL reset_mid_burst: got flags=%b data=%h count=%h, required 000000 00 0000", flags, thr_data, tx_count);
                else pass_cnt++;
                reset = 1'b0;
                exp_count = 16'h0000;
                chk_cnt++;
                if (exp_q.size() != 0) $display("FAIL reset_mid_queue: got %0d bytes pending, required 0", exp_q.size());
                else pass_cnt++;
                repeat (3) @(negedge m_clk);
                chk_cnt++;
                if (busy !== 1'b0) $display("FAIL reset_mid_idle: got busy=%b, required 0", busy);
                else pass_cnt++;
                return;
            end
            if (stall && idx == 2 && !stalled) begin
                stalled = 1'b1; bad = 1'b0;
                thr_ready = 1'b0;
                dma_data  = bytes[8*idx +: 8];
                repeat (5) begin
                    @(negedge m_clk);
                    if (dma_rdy !== 1'b0 || thr_load !== 1'b0) bad = 1'b1;
                end
                chk_cnt++;
                if (bad) $display("FAIL backpressure: got rdy or load while thr_ready=0, required none");
                else pass_cnt++;
                thr_ready = 1'b1;
            end
        end
        dma_valid = 1'b0;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 20) begin @(negedge m_clk); cyc++; end
        chk_cnt++;
        if (busy !== 1'b0 || dma_req !== 1'b0) $display("FAIL burst_end: got busy=%b req=%b, required 0 0", busy, dma_req);
        else pass_cnt++;
        chk_cnt++;
        if (tx_count !== exp_count || exp_q.size() != 0)
            $display("FAIL burst_count: got count=%h pending=%0d, required %h 0", tx_count, exp_q.size(), exp_count);
        else pass_cnt++;
    endtask

    task automatic test_dma_burst();
        do_burst(32'h4433_2211, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_burst(32'hD4C3_B2A1, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        int cyc;
        fifo_empty = 1'b1; thr_ready = 1'b1; fifo_en = 1'b1; dma_mode = 1'b1;
        cyc = 0;
        while (dma_req !== 1'b1 && cyc < 20) begin @(negedge m_clk); cyc++; end
        dma_mode = 1'b0;
        @(negedge m_clk);
        chk_cnt++;
        if (cyc >= 20 || dma_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort: got req=%b busy=%b after clear, required 0 0", dma_req, busy);
        else pass_cnt++;
        repeat (3) @(negedge m_clk);
        chk_cnt++;
        if (tx_count !== exp_count) $display("FAIL abort_count: got %h, required %h", tx_count, exp_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        do_burst(32'h0403_0201, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        @(negedge m_clk);
        force dut.tx_count = 16'hFFFF;
        @(negedge m_clk);
        release dut.tx_count;
        exp_count = 16'hFFFF;
        @(negedge m_clk);
        chk_cnt++;
        if (tx_count !== 16'hFFFF) $display("FAIL wrap_preload: got %h, required ffff", tx_count);
        else pass_cnt++;
        do_fifo_byte(1'b1, 1'b0, 8'h5A);
        chk_cnt++;
        if (tx_count !== 16'h0000) $display("FAIL wrap: got %h, required 0000", tx_count);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; fifo_en = 1'b0; dma_mode = 1'b0; fifo_empty = 1'b1;
        fifo_data = 8'h00; dma_ack = 1'b0; dma_valid = 1'b0; dma_data = 8'h00;
        thr_ready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_fifo_path();
        test_idle_hold();
        test_fifo_sel_override();
        test_dma_burst();
        test_backpressure();
        test_abort();
        test_reset_mid_burst();
        test_wrap();
        repeat (2) @(negedge m_clk);
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL final_queue: got %0d bytes never loaded, required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/tx_src_ctrl.md
TX_SRC_CTRL -- requirements
Module: tx_src_ctrl

Interface
REQ-001 SHALL have parameter BURST, default 4: bytes moved per DMA request; legal range 1..255.
REQ-002 SHALL have port m_clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high; clock m_clk.
REQ-004 SHALL have port fifo_en  in  1  FIFO enable from control register.
REQ-005 SHALL have port dma_mode  in  1  DMA mode select from control register.
REQ-006 SHALL have port fifo_empty  in  1  TX FIFO empty flag.
REQ-007 SHALL have port fifo_rd  out  1  one-cycle TX FIFO pop strobe.
REQ-008 SHALL have port fifo_data  in  8  FIFO read data, valid the cycle after fifo_rd.
REQ-009 SHALL have port dma_req  out  1  DMA service request.
REQ-010 SHALL have port dma_ack  in  1  DMA grant.
REQ-011 SHALL have port dma_valid  in  1  DMA byte valid.
REQ-012 SHALL have port dma_rdy  out  1  controller can accept a DMA byte.
REQ-013 SHALL have port dma_data  in  8  DMA byte.
REQ-014 SHALL have port thr_ready  in  1  transmitter holding register empty.
REQ-015 SHALL have port thr_load  out  1  one-cycle load strobe to holding register.
REQ-016 SHALL have port thr_data  out  8  byte to transmitter, registered.
REQ-017 SHALL have ports busy  out  1 (state not IDLE), src_dma  out  1 (latched source), tx_count  out  16 (bytes loaded).

Function
REQ-018 SHALL use states IDLE, FRD, FWAIT, LOAD, DREQ, DXFER, DLOAD.
REQ-019 SHALL compute dma_sel = fifo_en AND dma_mode, sampled only in IDLE and latched into src_dma; changes outside IDLE take effect on the next IDLE.
REQ-020 IDLE -> FRD when dma_sel=0, fifo_empty=0, thr_ready=1; IDLE -> DREQ when dma_sel=1, thr_ready=1; otherwise stay IDLE.
REQ-021 FRD: fifo_rd=1 for exactly that cycle; unconditional -> FWAIT.
REQ-022 FWAIT: on exit edge capture fifo_data into thr_data; -> LOAD.
REQ-023 LOAD: thr_load=1 for one cycle; tx_count increments; -> IDLE; FIFO path latency = 3 cycles from qualifying IDLE edge to thr_load.
REQ-024 DREQ: dma_req=1 until dma_ack sampled high, then -> DXFER with beat counter cleared; if dma_sel falls while in DREQ, -> IDLE with dma_req deasserted, no bytes moved.
REQ-025 DXFER: dma_rdy = thr_ready; byte accepted on edge where dma_valid=1 and dma_rdy=1: dma_data -> thr_data, beat counter +1, -> DLOAD.
REQ-026 DLOAD: thr_load=1, dma_rdy=0, tx_count +1; -> IDLE if beat counter = BURST, else -> DXFER.
REQ-027 Once DXFER entered, burst SHALL complete all BURST bytes regardless of fifo_en/dma_mode changes.
REQ-028 dma_rdy SHALL be 0 in every state except DXFER; at most one thr_load per two cycles.
REQ-029 Beat counter 8 bits; tx_count 16 bits, wraps 0xFFFF -> 0x0000 without flag.
REQ-030 fifo_en=0 with dma_mode=1 SHALL use the FIFO path (dma_sel=0).
REQ-031 thr_data SHALL hold its last value between loads.

Reset
REQ-032 reset=1 at an edge SHALL force state IDLE; fifo_rd, dma_req, dma_rdy, thr_load, busy, src_dma = 0; thr_data = 0x00; tx_count and beat counter = 0.
REQ-033 Reset SHALL override all transitions, including mid-burst; dma_req low from the cycle after the reset edge.

Verification
REQ-034 FIFO path: fifo_en=1, dma_mode=0, fifo_empty=0, thr_ready=1, fifo_data=0xA5 after pop -> fifo_rd one cycle, thr_load 3 cycles after start with thr_data=0xA5, tx_count=1.
REQ-035 DMA burst: fifo_en=1, dma_mode=1, BURST=4, dma_ack after 2 cycles, bytes 0x11,0x22,0x33,0x44 -> four thr_load pulses in order, dma_req low after ack, IDLE, tx_count=4.
REQ-036 Backpressure: thr_ready=0 for 5 cycles mid-burst with dma_valid=1 -> dma_rdy=0, no loads, no lost/duplicate bytes; burst resumes.
REQ-037 Abort: dma_mode cleared in DREQ before dma_ack -> dma_req falls next edge, IDLE, tx_count unchanged.
REQ-038 Reset mid-burst after byte 2 of 4 -> all outputs to reset values next cycle; tx_count=0.
REQ-039 Wrap: preload tx_count to 0xFFFF via 65535 loads (or force) then one FIFO load -> tx_count=0x0000.
